// File: rtl/hex_scan_pkg.sv
// Purpose: shared seven-segment encoding for the hex display scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hex_scan_pkg;

    // Bit positions inside a seg_n word, ordered {g,f,e,d,c,b,a}.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Purpose: nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_7seg
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Purpose: scans a 32-bit hex word onto a multiplexed common-anode 7-seg display.
// Latency: outputs registered, 1 cycle behind the scan counters.
// Backpressure: none; inputs are sampled once per frame.
module hex_display_scanner
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           hex_value,
    input  logic [7:0]            dp_in,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = SW + 5;

    logic [SW-1:0]         slot_cnt;
    logic [DW-1:0]         digit_idx;
    logic [31:0]           sh_value;
    logic [7:0]            sh_dp;
    logic                  sh_lz;
    logic [3:0]            sh_bright;

    logic                  frame_start;
    logic                  slot_last;
    logic                  digit_last;
    logic [31:0]           eff_value;
    logic [7:0]            eff_dp;
    logic                  eff_lz;
    logic [3:0]            eff_bright;
    logic [NUM_DIGITS-1:0] blank;
    logic                  lz_run;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_next;
    logic [PW-1:0]         on_prod;
    logic [PW-1:0]         on_cycles;
    logic [PW-1:0]         slot_ext;
    logic                  lit;
    logic [NUM_DIGITS-1:0] en_n_next;

    assign frame_start = (slot_cnt == '0) && (digit_idx == '0);
    assign slot_last   = (slot_cnt == SW'(SCAN_DIV - 1));
    assign digit_last  = (digit_idx == DW'(NUM_DIGITS - 1));

    // The frame-start cycle already displays digit 0, so it must see the
    // values being latched rather than the previous frame's shadow.
    assign eff_value  = frame_start ? hex_value  : sh_value;
    assign eff_dp     = frame_start ? dp_in      : sh_dp;
    assign eff_lz     = frame_start ? lz_blank   : sh_lz;
    assign eff_bright = frame_start ? brightness : sh_bright;

    always_comb begin
        blank  = '0;
        lz_run = eff_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run   = lz_run && (eff_value[4*i +: 4] == 4'h0);
            blank[i] = lz_run;
        end
    end

    assign cur_nibble = eff_value[{digit_idx, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg_n  (dec_seg)
    );

    assign seg_next = blank[digit_idx] ? SEG_BLANK : dec_seg;

    // Full-width product before the shift keeps SCAN_DIV*16 exact.
    assign on_prod   = (PW'(eff_bright) + PW'(1)) * PW'(SCAN_DIV);
    assign on_cycles = on_prod >> 4;
    assign slot_ext  = PW'(slot_cnt);
    assign lit       = (slot_ext >= PW'(GUARD)) && (slot_ext < on_cycles);

    always_comb begin
        en_n_next = '1;
        if (lit) begin
            en_n_next[digit_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_lz      <= 1'b0;
            sh_bright  <= '0;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            digit_en_n <= '1;
            frame_done <= 1'b0;
        end else begin
            if (slot_last) begin
                slot_cnt  <= '0;
                digit_idx <= digit_last ? '0 : digit_idx + DW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
            if (frame_start) begin
                sh_value  <= hex_value;
                sh_dp     <= dp_in;
                sh_lz     <= lz_blank;
                sh_bright <= brightness;
            end
            seg_n      <= seg_next;
            dp_n       <= ~eff_dp[digit_idx];
            digit_en_n <= en_n_next;
            frame_done <= slot_last && digit_last;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with a per-cycle expected-output queue.
module tb_hex_display_scanner;

    localparam int ND = 8;
    localparam int SD = 16;
    localparam int GD = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   hex_value;
    logic [7:0]    dp_in;
    logic          lz_blank;
    logic [3:0]    brightness;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [ND-1:0] digit_en_n;
    logic          frame_done;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GUARD      (GD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hex_value  (hex_value),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [7:0] en;
        logic       fd;
    } out_t;

    out_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int         m_slot = 0;
    int         m_digit = 0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [3:0]  m_br = '0;
    int         prev_slot = -1;
    int         prev_digit = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Predict the registered outputs of the coming edge, then compare after it.
    task automatic tick();
        out_t e;
        int   h;
        int   on;
        logic [3:0] nib;
        if (!reset_n) begin
            e = '{seg: 7'h7F, dp: 1'b1, en: 8'hFF, fd: 1'b0};
            m_slot = 0; m_digit = 0;
            m_val = '0; m_dp = '0; m_lz = 1'b0; m_br = '0;
            prev_slot = -1; prev_digit = -1;
        end else begin
            if (m_slot == 0 && m_digit == 0) begin
                m_val = hex_value; m_dp = dp_in; m_lz = lz_blank; m_br = brightness;
            end
            h = 0;
            for (int i = 0; i < ND; i++) begin
                if (m_val[4*i +: 4] != 4'h0) h = i;
            end
            nib   = m_val[4*m_digit +: 4];
            e.seg = (m_lz && m_digit > h) ? 7'h7F : lut[nib];
            e.dp  = ~m_dp[m_digit];
            on    = ((int'(m_br) + 1) * SD) >> 4;
            e.en  = (m_slot >= GD && m_slot < on) ? ~(8'h01 << m_digit) : 8'hFF;
            e.fd  = (m_slot == SD - 1 && m_digit == ND - 1);
            prev_slot = m_slot; prev_digit = m_digit;
            if (m_slot == SD - 1) begin
                m_slot  = 0;
                m_digit = (m_digit == ND - 1) ? 0 : m_digit + 1;
            end else begin
                m_slot = m_slot + 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("outputs", {15'b0, seg_n, dp_n, digit_en_n, frame_done},
                         {15'b0, e.seg, e.dp, e.en, e.fd});
    endtask

    // Advance until the outputs reflect scan position (d, s).
    task automatic run_to(input int d, input int s);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(prev_digit == d && prev_slot == s) && k < 300);
        check("run_to", 32'(prev_digit == d && prev_slot == s), 32'd1);
    endtask

    initial begin
        logic [6:0] exp_lz [8];
        int fd_cnt;
        int lit_cnt;

        reset_n    = 1'b0;
        hex_value  = 32'h89AB_CDEF;
        dp_in      = 8'h00;
        lz_blank   = 1'b0;
        brightness = 4'd15;

        repeat (5) tick();
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_en", 32'(digit_en_n), 32'hFF);
        check("reset_fd", 32'(frame_done), 32'h0);
        check("reset_dp", 32'(dp_n), 32'h1);

        // Decode / scan
        reset_n = 1'b1;
        tick();
        check("guard_en", 32'(digit_en_n), 32'hFF);
        check("guard_seg", 32'(seg_n), 32'h0E);
        run_to(0, 5);
        check("slot0_en", 32'(digit_en_n), 32'hFE);
        check("slot0_seg", 32'(seg_n), 32'h0E);
        run_to(7, 10);
        check("slot7_en", 32'(digit_en_n), 32'h7F);
        check("slot7_seg", 32'(seg_n), 32'h00);
        fd_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        check("fd_per_frame", 32'(fd_cnt), 32'd1);

        // Mid-scan reset restarts at digit 0
        run_to(3, 7);
        reset_n = 1'b0;
        repeat (5) tick();
        check("midrst_seg", 32'(seg_n), 32'h7F);
        check("midrst_en", 32'(digit_en_n), 32'hFF);
        check("midrst_fd", 32'(frame_done), 32'h0);
        reset_n = 1'b1;
        tick();
        check("restart_pos", 32'(prev_digit * 100 + prev_slot), 32'd0);
        run_to(0, 3);
        check("restart_en", 32'(digit_en_n), 32'hFE);

        // Leading zeros
        hex_value = 32'h0000_0105;
        lz_blank  = 1'b1;
        exp_lz = '{7'h12, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        run_to(0, 0);
        for (int d = 0; d < ND; d++) begin
            run_to(d, 8);
            check($sformatf("lz105_d%0d", d), 32'(seg_n), 32'(exp_lz[d]));
        end
        hex_value = 32'h0;
        run_to(0, 0);
        for (int d = 0; d < ND; d++) begin
            run_to(d, 8);
            check($sformatf("lz0_d%0d", d), 32'(seg_n), (d == 0) ? 32'h40 : 32'h7F);
        end

        // Brightness and guard
        hex_value  = 32'h89AB_CDEF;
        lz_blank   = 1'b0;
        brightness = 4'd3;
        run_to(0, 0);
        for (int s = 0; s < SD; s++) begin
            run_to(2, s);
            check($sformatf("br3_s%0d", s), 32'(digit_en_n),
                  (s == 2 || s == 3) ? 32'hFB : 32'hFF);
        end
        brightness = 4'd0;
        run_to(0, 0);
        lit_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (digit_en_n != 8'hFF) lit_cnt++;
        end
        check("br0_dark", 32'(lit_cnt), 32'd0);

        // Frame coherence
        brightness = 4'd15;
        hex_value  = 32'h1111_1111;
        run_to(0, 0);
        run_to(3, 4);
        hex_value = 32'h2222_2222;
        for (int d = 3; d < ND; d++) begin
            run_to(d, 8);
            check($sformatf("coh_old_d%0d", d), 32'(seg_n), 32'h79);
        end
        for (int d = 0; d < ND; d++) begin
            run_to(d, 8);
            check($sformatf("coh_new_d%0d", d), 32'(seg_n), 32'h24);
        end

        // Decimal point on blanked digits
        dp_in     = 8'h81;
        lz_blank  = 1'b1;
        hex_value = 32'h0;
        run_to(0, 0);
        for (int d = 0; d < ND; d++) begin
            run_to(d, 8);
            check($sformatf("dp_d%0d", d), 32'(dp_n), (d == 0 || d == 7) ? 32'h0 : 32'h1);
        end
        check("dp_d7_seg", 32'(seg_n), 32'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream consumer of the 32-bit hex-display PIO output word; drives a time-multiplexed 8-digit common-anode seven-segment display.
- Splits the word into 8 nibbles (digit 0 = bits 3:0) and decodes each to active-low segments.
- Scans one digit at a time, with frame-coherent update, leading-zero blanking and PWM brightness.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (nibbles of hex_value).
- SCAN_DIV, 50000, clock cycles per digit slot; minimum 16.
- GUARD, 64, cycles at the start of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- hex_value  in  32  word from the display PIO out_port
- dp_in  in  8  decimal-point request per digit, 1 = on
- lz_blank  in  1  1 = suppress leading zeros
- brightness  in  4  0 = dimmest, 15 = full
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low
- dp_n  out  1  decimal point, active low
- digit_en_n  out  NUM_DIGITS  one-cold digit anode enable
- frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n, sampled at the clk rising edge.
- Reset values: slot_cnt=0, digit_idx=0, shadow regs=0, seg_n=7'h7F, dp_n=1, digit_en_n=all 1, frame_done=0. Reset mid-frame aborts the scan immediately; the next frame restarts at digit 0.
- slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx increments 0..NUM_DIGITS-1, then wraps to 0.
- Frame start: the cycle where slot_cnt==0 and digit_idx==0, including the first cycle after reset release.
  - Latches hex_value, dp_in, lz_blank and brightness into shadow registers.
  - Mid-frame input changes are ignored until the next frame start (no tearing).
- Leading-zero mask, computed from the shadow value:
  - When lz_blank=1, digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked, up to the first nonzero nibble.
  - Digit 0 is never blanked.
  - A blanked digit drives seg_n=7'h7F; its dp still follows shadow dp.
- on_cycles = ((brightness+1)*SCAN_DIV)>>4, using shadow brightness.
  - The active digit is enabled only while GUARD <= slot_cnt < on_cycles.
  - If on_cycles <= GUARD, the digit stays dark for the whole slot.
  - At most one digit_en_n bit is low at any time.
- Outputs are registered: seg_n, dp_n and digit_en_n reflect the slot_cnt/digit_idx values of the previous cycle (latency 1).
  - seg_n and dp_n hold the current digit's pattern for the entire slot, including the guard period.
- frame_done pulses high for exactly one cycle, registered, on the cycle after slot_cnt==SCAN_DIV-1 with digit_idx==NUM_DIGITS-1.
- Decode table (seg_n, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Width rules:
  - Counters are sized $clog2 of their range.
  - on_cycles product is computed at $clog2(SCAN_DIV)+5 bits, with no truncation before the shift.

Decomposition:
- Package hex_scan_pkg: the 16-entry SEG_LUT constant (7-bit active-low), SEG_BLANK=7'h7F, and the seg-bit ordering.
- Sub-module hex_to_7seg: purely combinational nibble -> seg_n lookup using SEG_LUT, instantiated once on the muxed current nibble.
- Scan counters, shadow regs, leading-zero mask and PWM compare stay in hex_display_scanner.

Test Plan (bench uses SCAN_DIV=16, GUARD=2, NUM_DIGITS=8):
- Reset: hold reset_n=0 for 5 cycles mid-scan -> next cycle seg_n=7F, digit_en_n=FF, frame_done=0; scan restarts at digit 0.
- Decode/scan:
  - Stimulus: hex_value=32'h89AB_CDEF, brightness=15, lz_blank=0.
  - Slot 0 -> digit_en_n=FE with seg_n=0E during slot_cnt 2..15.
  - Slot 7 -> digit_en_n=7F with seg_n=00.
  - frame_done pulses exactly once every 128 cycles.
- Leading zeros:
  - hex_value=32'h0000_0105, lz_blank=1 -> digits 7..3 show 7F; digit 2=79, digit 1=40, digit 0=12.
  - hex_value=0, lz_blank=1 -> only digit 0 shows 40.
- Brightness/guard:
  - brightness=3 (on_cycles=4) -> digit enabled only at slot_cnt 2,3, output one cycle later.
  - brightness=0 (on_cycles=1 <= GUARD) -> digit_en_n stays all 1.
- Frame coherence: change hex_value from 1111_1111 to 2222_2222 during slot 3 -> remaining digits of that frame still decode 79; the next frame shows 24 on all digits.
- Decimal point: dp_in=8'h81, lz_blank=1, hex_value=0 -> dp_n=0 in slots 0 and 7 (slot 7 blanked, seg_n=7F); dp_n=1 in all other slots.
